// File: rtl/interrupt_vector_ctrl_if.sv
// Core-side bundle of the interrupt vector controller: raw requests, masks, PC hand-off and status.
// slave = controller view, master = core/board view.
interface interrupt_vector_ctrl_if #(
  parameter int NUM_IRQ = 4,
  parameter int PC_W    = 32
);
  logic [NUM_IRQ-1:0] irqIn;
  logic [NUM_IRQ-1:0] irqMask;
  logic [PC_W-1:0]    pcCurrent;
  logic               pipeDrained;
  logic               retInt;
  logic               intStall;
  logic               pcLoad;
  logic [PC_W-1:0]    pcNext;
  logic [1:0]         onInterrupt;
  logic [3:0]         activeId;

  modport slave (
    input  irqIn, irqMask, pcCurrent, pipeDrained, retInt,
    output intStall, pcLoad, pcNext, onInterrupt, activeId
  );

  modport master (
    output irqIn, irqMask, pcCurrent, pipeDrained, retInt,
    input  intStall, pcLoad, pcNext, onInterrupt, activeId
  );
endinterface

// File: rtl/interrupt_vector_ctrl.sv
// Interrupt controller: synchronises and latches request edges, drains the core, vectors and returns.
// Optional nested preemption with a saved-PC stack is built when IRQ_NEST_EN is defined.
module interrupt_vector_ctrl #(
  parameter int NUM_IRQ    = 4,
  parameter int PC_W       = 32,
  parameter int VEC_BASE   = 32,
  parameter int VEC_STRIDE = 64,
  parameter int NEST_DEPTH = 2
) (
  input logic                   clock,
  input logic                   reset_n,
  interrupt_vector_ctrl_if.slave irq_bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_VECTOR  = 3'd2,
    S_SERVICE = 3'd3,
    S_RETURN  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] edge_s, eligible_s, clr_s;
  logic [1:0]         arm_q;
  logic [3:0]         active_q, active_d, winner_s;
  logic               any_s;
  logic [PC_W-1:0]    saved_q, saved_d, vec_s;
  logic               stall_s, load_s;
  logic [PC_W-1:0]    next_s;
  logic [1:0]         on_s;
  logic [3:0]         id_s;

  function automatic logic [3:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      idx = v[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

  // Two-stage synchroniser, edge history and post-reset arming of the edge detector
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= 2'd0;
    end else begin
      sync1_q <= irq_bus.irqIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      arm_q   <= (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    end
  end

  // Lines already high when reset releases are levels, not new edges
  assign edge_s     = (arm_q == 2'd3) ? (sync2_q & ~prev_q) : '0;
  assign eligible_s = pending_q & irq_bus.irqMask;
  assign any_s      = |eligible_s;
  assign winner_s   = lowest_idx(eligible_s);
  assign vec_s      = PC_W'(VEC_BASE) + PC_W'(active_q) * PC_W'(VEC_STRIDE);
  assign pending_d  = (pending_q & ~clr_s) | edge_s;

`ifdef IRQ_NEST_EN
  localparam int SP_W = $clog2(NEST_DEPTH + 1);

  logic [PC_W-1:0] stk_pc_q [NEST_DEPTH];
  logic [3:0]      stk_id_q [NEST_DEPTH];
  logic [SP_W-1:0] sp_q;
  logic            push_s, pop_s, preempt_s;

  assign preempt_s = any_s && (winner_s < active_q) && (sp_q != SP_W'(NEST_DEPTH));

  // Saved-context stack for preempted services
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sp_q <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stk_pc_q[i] <= '0;
        stk_id_q[i] <= 4'd0;
      end
    end else if (push_s) begin
      stk_pc_q[sp_q] <= saved_q;
      stk_id_q[sp_q] <= active_q;
      sp_q           <= sp_q + SP_W'(1);
    end else if (pop_s) begin
      sp_q <= sp_q - SP_W'(1);
    end else begin
      sp_q <= sp_q;
    end
  end
`endif

  // State, captured line, saved PC and pending latches
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      active_q  <= 4'd0;
      saved_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      saved_q   <= saved_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic; a new edge on the line being cleared survives as a fresh request
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    saved_d  = saved_q;
    clr_s    = '0;
`ifdef IRQ_NEST_EN
    push_s   = 1'b0;
    pop_s    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_s) begin
          state_d  = S_DRAIN;
          active_d = winner_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (irq_bus.pipeDrained) begin
          saved_d = irq_bus.pcCurrent;
          clr_s   = NUM_IRQ'(1'b1) << active_q;
          state_d = S_VECTOR;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_VECTOR: state_d = S_SERVICE;
      S_SERVICE: begin
        if (irq_bus.retInt) begin
          state_d = S_RETURN;
`ifdef IRQ_NEST_EN
        end else if (preempt_s) begin
          push_s   = 1'b1;
          active_d = winner_s;
          state_d  = S_DRAIN;
`endif
        end else begin
          state_d = S_SERVICE;
        end
      end
      S_RETURN: begin
`ifdef IRQ_NEST_EN
        if (sp_q != '0) begin
          pop_s    = 1'b1;
          saved_d  = stk_pc_q[sp_q - SP_W'(1)];
          active_d = stk_id_q[sp_q - SP_W'(1)];
          state_d  = S_SERVICE;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state only
  always_comb begin
    stall_s = 1'b0;
    load_s  = 1'b0;
    next_s  = '0;
    on_s    = 2'b00;
    id_s    = 4'd0;
    case (state_q)
      S_IDLE: begin
        on_s = 2'b00;
      end
      S_DRAIN: begin
        stall_s = 1'b1;
        on_s    = 2'b01;
        id_s    = active_q;
      end
      S_VECTOR: begin
        load_s = 1'b1;
        next_s = vec_s;
        on_s   = 2'b11;
        id_s   = active_q;
      end
      S_SERVICE: begin
        on_s = 2'b11;
        id_s = active_q;
      end
      S_RETURN: begin
        load_s = 1'b1;
        next_s = saved_q;
        on_s   = 2'b10;
        id_s   = active_q;
      end
      default: on_s = 2'b00;
    endcase
  end

  assign irq_bus.intStall    = stall_s;
  assign irq_bus.pcLoad      = load_s;
  assign irq_bus.pcNext      = next_s;
  assign irq_bus.onInterrupt = on_s;
  assign irq_bus.activeId    = id_s;

endmodule

// File: tb/tb_interrupt_vector_ctrl.sv
// Self-checking bench for interrupt_vector_ctrl: vector table, directed corner sequences, random vs model.
module tb_interrupt_vector_ctrl;

  localparam int VB = 32;
  localparam int VS = 64;

  logic clock = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  interrupt_vector_ctrl_if #(.NUM_IRQ(4), .PC_W(32)) bus ();

  interrupt_vector_ctrl #(
    .NUM_IRQ(4), .PC_W(32), .VEC_BASE(VB), .VEC_STRIDE(VS), .NEST_DEPTH(2)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .irq_bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  irq;
    logic        drained;
    logic        ret;
    logic        st;
    logic        ld;
    logic [31:0] nx;
    logic [1:0]  on;
    logic [3:0]  id;
  } vec_t;

  typedef enum int {P_IDLE, P_DRAIN, P_VECTOR, P_SERVICE, P_RETURN} ph_t;

  vec_t tbl[11];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string name, input logic st, input logic ld,
                           input logic [31:0] nx, input logic [1:0] on, input logic [3:0] id);
    n_tests++;
    if (bus.intStall !== st || bus.pcLoad !== ld || bus.pcNext !== nx ||
        bus.onInterrupt !== on || bus.activeId !== id) begin
      n_fail++;
      $display("FAIL %s: got stall=%0b load=%0b next=%h on=%b id=%0d, want stall=%0b load=%0b next=%h on=%b id=%0d",
               name, bus.intStall, bus.pcLoad, bus.pcNext, bus.onInterrupt, bus.activeId,
               st, ld, nx, on, id);
    end
  endtask

  task automatic wait_on(input logic [1:0] code, input int budget, input string name);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (bus.onInterrupt !== code && k < budget);
    n_tests++;
    if (bus.onInterrupt !== code) begin
      n_fail++;
      $display("FAIL %s: onInterrupt=%b after %0d cycles, want %b", name, bus.onInterrupt, k, code);
    end
  endtask

  function automatic logic [31:0] vec_of(input int id);
    longint v;
    v = (longint'(VB) + longint'(id) * longint'(VS)) % (longint'(1) << 32);
    return 32'(v);
  endfunction

  task automatic pulse_irq(input logic [3:0] v);
    bus.irqIn = v;
    tick();
    tick();
    bus.irqIn = 4'h0;
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.irqIn       = 4'hF;
    bus.irqMask     = 4'hF;
    bus.pcCurrent   = 32'h0;
    bus.pipeDrained = 1'b0;
    bus.retInt      = 1'b0;

    // reset with all requests high, then release with the level still present
    tick();
    tick();
    check_out("reset_hold", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_out("reset_level_no_edge", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);
    end
    bus.irqIn = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("idle_after_release", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);
    end

    // single request on line 1, cycle-exact
    tbl[0]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 4'd0};
    tbl[1]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 4'd0};
    tbl[2]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 4'd0};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'b01, 4'd1};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'b01, 4'd1};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h60, 2'b11, 4'd1};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  2'b11, 4'd1};
    tbl[7]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  2'b11, 4'd1};
    tbl[8]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 2'b10, 4'd1};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 4'd0};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 4'd0};
    bus.pcCurrent = 32'h40;
    for (int r = 0; r < 11; r++) begin
      bus.irqIn       = tbl[r].irq;
      bus.pipeDrained = tbl[r].drained;
      bus.retInt      = tbl[r].ret;
      tick();
      check_out($sformatf("table_row%0d", r), tbl[r].st, tbl[r].ld, tbl[r].nx, tbl[r].on, tbl[r].id);
    end

    // priority with line 0 masked, then unmask in idle
    bus.pcCurrent   = 32'h100;
    bus.pipeDrained = 1'b1;
    bus.irqMask     = 4'b1110;
    pulse_irq(4'b0101);
    wait_on(2'b01, 10, "prio_wait_drain");
    check_out("prio_drain_l2", 1'b1, 1'b0, 32'h0, 2'b01, 4'd2);
    tick(); check_out("prio_vector_l2", 1'b0, 1'b1, 32'hA0, 2'b11, 4'd2);
    tick(); check_out("prio_service_l2", 1'b0, 1'b0, 32'h0, 2'b11, 4'd2);
    bus.retInt = 1'b1;
    tick(); check_out("prio_return_l2", 1'b0, 1'b1, 32'h100, 2'b10, 4'd2);
    bus.retInt = 1'b0;
    tick(); check_out("prio_idle", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);
    tick(); check_out("masked_stays_idle", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);
    bus.irqMask = 4'hF;
    tick(); check_out("unmask_drain_l0", 1'b1, 1'b0, 32'h0, 2'b01, 4'd0);
    tick(); check_out("unmask_vector_l0", 1'b0, 1'b1, 32'h20, 2'b11, 4'd0);
    tick();
    bus.retInt = 1'b1;
    tick(); check_out("unmask_return_l0", 1'b0, 1'b1, 32'h100, 2'b10, 4'd0);
    bus.retInt = 1'b0;
    tick(); check_out("unmask_idle", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);

    // back-to-back: line 3 arrives during line 1 service; mask line 3 after capture
    bus.pcCurrent = 32'h200;
    pulse_irq(4'b0010);
    wait_on(2'b01, 10, "b2b_wait_drain");
    check_out("b2b_drain_l1", 1'b1, 1'b0, 32'h0, 2'b01, 4'd1);
    tick(); check_out("b2b_vector_l1", 1'b0, 1'b1, 32'h60, 2'b11, 4'd1);
    tick(); check_out("b2b_service_l1", 1'b0, 1'b0, 32'h0, 2'b11, 4'd1);
    bus.irqIn = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.irqIn = 4'b0000;
      tick();
      check_out("b2b_service_hold", 1'b0, 1'b0, 32'h0, 2'b11, 4'd1);
    end
    bus.retInt = 1'b1;
    tick(); check_out("b2b_return_l1", 1'b0, 1'b1, 32'h200, 2'b10, 4'd1);
    bus.retInt = 1'b0;
    tick(); check_out("b2b_idle_gap", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);
    tick(); check_out("b2b_drain_l3", 1'b1, 1'b0, 32'h0, 2'b01, 4'd3);
    bus.irqMask = 4'b0111;
    tick(); check_out("b2b_vector_l3_masked", 1'b0, 1'b1, 32'hE0, 2'b11, 4'd3);
    tick(); check_out("b2b_service_l3", 1'b0, 1'b0, 32'h0, 2'b11, 4'd3);
    bus.irqMask = 4'hF;
    bus.retInt  = 1'b1;
    tick(); check_out("b2b_return_l3", 1'b0, 1'b1, 32'h200, 2'b10, 4'd3);
    bus.retInt = 1'b0;
    tick(); check_out("b2b_idle", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);

    // long drain with a higher-priority edge arriving; then spurious return in idle
    bus.pcCurrent   = 32'h300;
    bus.pipeDrained = 1'b0;
    pulse_irq(4'b0100);
    wait_on(2'b01, 10, "drain_wait");
    for (int i = 0; i < 10; i++) begin
      bus.irqIn = (i < 2) ? 4'b0001 : 4'b0000;
      tick();
      check_out("drain_hold_frozen", 1'b1, 1'b0, 32'h0, 2'b01, 4'd2);
    end
    bus.pipeDrained = 1'b1;
    tick(); check_out("drain_vector_l2", 1'b0, 1'b1, 32'hA0, 2'b11, 4'd2);
    tick();
    bus.retInt = 1'b1;
    tick(); check_out("drain_return_l2", 1'b0, 1'b1, 32'h300, 2'b10, 4'd2);
    bus.retInt = 1'b0;
    tick(); check_out("drain_idle", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);
    tick(); check_out("chain_drain_l0", 1'b1, 1'b0, 32'h0, 2'b01, 4'd0);
    tick(); check_out("chain_vector_l0", 1'b0, 1'b1, 32'h20, 2'b11, 4'd0);
    tick();
    bus.retInt = 1'b1;
    tick(); check_out("chain_return_l0", 1'b0, 1'b1, 32'h300, 2'b10, 4'd0);
    bus.retInt = 1'b0;
    tick();
    bus.retInt = 1'b1;
    tick(); check_out("spurious_ret", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);
    bus.retInt = 1'b0;
    tick(); check_out("spurious_ret_after", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);

`ifdef IRQ_NEST_EN
    // nested preemption of line 2 by line 0, LIFO restore
    bus.pcCurrent = 32'h600;
    pulse_irq(4'b0100);
    wait_on(2'b01, 10, "nest_wait_l2");
    tick(); check_out("nest_vector_l2", 1'b0, 1'b1, 32'hA0, 2'b11, 4'd2);
    tick();
    bus.pcCurrent = 32'h700;
    pulse_irq(4'b0001);
    wait_on(2'b01, 10, "nest_wait_preempt");
    check_out("nest_drain_l0", 1'b1, 1'b0, 32'h0, 2'b01, 4'd0);
    tick(); check_out("nest_vector_l0", 1'b0, 1'b1, 32'h20, 2'b11, 4'd0);
    tick();
    bus.retInt = 1'b1;
    tick(); check_out("nest_return_inner", 1'b0, 1'b1, 32'h700, 2'b10, 4'd0);
    bus.retInt = 1'b0;
    tick(); check_out("nest_resume_outer", 1'b0, 1'b0, 32'h0, 2'b11, 4'd2);
    bus.retInt = 1'b1;
    tick(); check_out("nest_return_outer", 1'b0, 1'b1, 32'h600, 2'b10, 4'd2);
    bus.retInt = 1'b0;
    tick(); check_out("nest_idle", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);
`endif

    // reset during service with a request pending: nothing resumes afterwards
    bus.pcCurrent = 32'h400;
    pulse_irq(4'b0010);
    wait_on(2'b01, 10, "rst_wait_drain");
    tick();
    tick(); check_out("rst_in_service", 1'b0, 1'b0, 32'h0, 2'b11, 4'd1);
    pulse_irq(4'b1000);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_out("reset_mid_service", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_out("after_reset_idle", 1'b0, 1'b0, 32'h0, 2'b00, 4'd0);
    end

`ifndef IRQ_NEST_EN
    // random stimulus against a cycle-level reference model of the rules
    begin
      ph_t         m_ph;
      logic [3:0]  m_pend, m_id, cur_irq, edges, elig, e_id;
      logic [31:0] m_saved, e_nx;
      logic [3:0]  hist[$];
      logic        e_st, e_ld;
      logic [1:0]  e_on;
      m_ph    = P_IDLE;
      m_pend  = 4'h0;
      m_id    = 4'd0;
      m_saved = 32'h0;
      cur_irq = 4'h0;
      hist    = '{4'h0, 4'h0, 4'h0};
      for (int c = 0; c < 400; c++) begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(7) == 0) cur_irq[b] = ~cur_irq[b];
        end
        if ($urandom_range(15) == 0) bus.irqMask = 4'($urandom);
        bus.irqIn       = cur_irq;
        bus.pcCurrent   = $urandom;
        bus.pipeDrained = 1'($urandom_range(1));
        bus.retInt      = ($urandom_range(3) == 0);
        // a request is seen when the input was high two cycles back and low three back
        edges = hist[$-1] & ~hist[$-2];
        elig  = m_pend & bus.irqMask;
        case (m_ph)
          P_IDLE: begin
            if (elig != 4'h0) begin
              m_ph = P_DRAIN;
              for (int i = 3; i >= 0; i--) if (elig[i]) m_id = 4'(i);
            end
          end
          P_DRAIN: begin
            if (bus.pipeDrained) begin
              m_saved        = bus.pcCurrent;
              m_pend[m_id]   = 1'b0;
              m_ph           = P_VECTOR;
            end
          end
          P_VECTOR:  m_ph = P_SERVICE;
          P_SERVICE: if (bus.retInt) m_ph = P_RETURN;
          default:   m_ph = P_IDLE;
        endcase
        m_pend = m_pend | edges;
        hist.push_back(cur_irq);
        hist.pop_front();
        tick();
        e_st = (m_ph == P_DRAIN);
        e_ld = (m_ph == P_VECTOR) || (m_ph == P_RETURN);
        e_nx = (m_ph == P_VECTOR) ? vec_of(int'(m_id)) : ((m_ph == P_RETURN) ? m_saved : 32'h0);
        e_on = (m_ph == P_DRAIN) ? 2'b01 : (m_ph == P_RETURN) ? 2'b10 :
               (m_ph == P_IDLE) ? 2'b00 : 2'b11;
        e_id = (m_ph == P_IDLE) ? 4'd0 : m_id;
        check_out($sformatf("rand_cycle%0d", c), e_st, e_ld, e_nx, e_on, e_id);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
